grant_burst_ctrl: RTL and testbench

- Downstream stage of the two-client arbiter. Consumes o_grant1/o_grant2 and moves the granted client's burst onto one shared valid/ready sink.
- Latches ownership at grant and runs a beat counter. Pulses per-beat fetch strobes back to the owning client. Signals burst completion so the client can drop its request.

---
 rtl/grant_burst_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_grant_burst_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/grant_burst_ctrl.sv
// grant_burst_ctrl: takes a one-hot grant from the two-client arbiter, latches
// the granted client as burst owner, and streams that client's beats onto a
// shared valid/ready sink, counting beats down from the length sampled at grant.
//
// Ports:
//   clock, reset_n             rising-edge clock, asynchronous active-low reset
//   i_grant1, i_grant2         arbiter grants (client1 wins if both are high)
//   clientN_data, clientN_len  per-client current beat data and burst length
//   bus_ready                  sink accepts the presented beat
//   o_bus_valid/data/owner     sink side; data is forced to 0 when not valid
//   o_beat_reqN                beat accepted for client N this cycle
//   o_doneN                    one-cycle pulse when client N's burst completes
//   o_abort                    one-cycle pulse when a burst is dropped on stall
//   o_busy                     high while a burst is in progress or finishing
//
// Build option: define XFER_TIMEOUT_EN to abort a burst after TIMEOUT_CYCLES
// consecutive stalled cycles. Without it o_abort is tied low and the transfer
// waits on bus_ready indefinitely.
module grant_burst_ctrl #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned LEN_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_grant1,
    input  logic              i_grant2,
    input  logic [DATA_W-1:0] client1_data,
    input  logic [LEN_W-1:0]  client1_len,
    input  logic [DATA_W-1:0] client2_data,
    input  logic [LEN_W-1:0]  client2_len,
    input  logic              bus_ready,
    output logic              o_bus_valid,
    output logic [DATA_W-1:0] o_bus_data,
    output logic [1:0]        o_bus_owner,
    output logic              o_beat_req1,
    output logic              o_beat_req2,
    output logic              o_done1,
    output logic              o_done2,
    output logic              o_abort,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_C1   = 2'b01;
    localparam logic [1:0] OWN_C2   = 2'b10;

    state_t           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [LEN_W-1:0] beats_q, beats_d;
    logic             accept;

`ifdef XFER_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               aborted_q, aborted_d;
`endif

    // A beat only exists in XFER, where beats_q is always non-zero.
    assign accept = (state_q == S_XFER) && bus_ready;

    // State, owner and beat counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            beats_q <= beats_d;
        end
    end

`ifdef XFER_TIMEOUT_EN
    // Stall counter and abort flag; the flag selects abort vs done in DONE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            aborted_q <= aborted_d;
        end
    end
`endif

    // Next-state, ownership latch and beat countdown.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        beats_d = beats_q;
`ifdef XFER_TIMEOUT_EN
        stall_d   = stall_q;
        aborted_d = aborted_q;
`endif
        unique case (state_q)
            S_IDLE: begin
`ifdef XFER_TIMEOUT_EN
                stall_d   = '0;
                aborted_d = 1'b0;
`endif
                if (i_grant1) begin
                    owner_d = OWN_C1;
                    beats_d = client1_len;
                    state_d = (client1_len == '0) ? S_DONE : S_XFER;
                end else if (i_grant2) begin
                    owner_d = OWN_C2;
                    beats_d = client2_len;
                    state_d = (client2_len == '0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (accept) begin
                    beats_d = beats_q - LEN_W'(1);
`ifdef XFER_TIMEOUT_EN
                    stall_d = '0;
`endif
                    if (beats_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
`ifdef XFER_TIMEOUT_EN
                // This stalled cycle is the TIMEOUT_CYCLES-th in a row.
                else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                    beats_d   = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Output decode from registered state; data and beat strobes follow inputs.
    always_comb begin
        o_bus_valid = 1'b0;
        o_bus_data  = '0;
        o_bus_owner = OWN_NONE;
        o_beat_req1 = 1'b0;
        o_beat_req2 = 1'b0;
        o_done1     = 1'b0;
        o_done2     = 1'b0;
        o_abort     = 1'b0;
        o_busy      = 1'b0;
        unique case (state_q)
            S_XFER: begin
                o_bus_valid = 1'b1;
                o_busy      = 1'b1;
                o_bus_owner = owner_q;
                o_bus_data  = (owner_q == OWN_C2) ? client2_data : client1_data;
                o_beat_req1 = accept && owner_q[0];
                o_beat_req2 = accept && owner_q[1];
            end
            S_DONE: begin
                o_busy = 1'b1;
`ifdef XFER_TIMEOUT_EN
                o_abort = aborted_q;
                o_done1 = owner_q[0] && !aborted_q;
                o_done2 = owner_q[1] && !aborted_q;
`else
                o_done1 = owner_q[0];
                o_done2 = owner_q[1];
`endif
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_grant_burst_ctrl.sv
`timescale 1ns/1ps
module tb_grant_burst_ctrl;

    localparam int unsigned DATA_W         = 8;
    localparam int unsigned LEN_W          = 4;
    localparam int unsigned TIMEOUT_CYCLES = 4;
    localparam int unsigned C1_BASE        = 32'hA0;
    localparam int unsigned C2_BASE        = 32'h50;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              i_grant1, i_grant2;
    logic [DATA_W-1:0] client1_data, client2_data;
    logic [LEN_W-1:0]  client1_len, client2_len;
    logic              bus_ready;
    logic              o_bus_valid;
    logic [DATA_W-1:0] o_bus_data;
    logic [1:0]        o_bus_owner;
    logic              o_beat_req1, o_beat_req2;
    logic              o_done1, o_done2, o_abort, o_busy;

    always #5 clock = ~clock;

    grant_burst_ctrl #(
        .DATA_W(DATA_W),
        .LEN_W(LEN_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .i_grant1(i_grant1),
        .i_grant2(i_grant2),
        .client1_data(client1_data),
        .client1_len(client1_len),
        .client2_data(client2_data),
        .client2_len(client2_len),
        .bus_ready(bus_ready),
        .o_bus_valid(o_bus_valid),
        .o_bus_data(o_bus_data),
        .o_bus_owner(o_bus_owner),
        .o_beat_req1(o_beat_req1),
        .o_beat_req2(o_beat_req2),
        .o_done1(o_done1),
        .o_done2(o_done2),
        .o_abort(o_abort),
        .o_busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    // Burst-level reference: who owns the bus, beats still owed, finishing flag.
    int m_owner;      // 0 none, 1 client1, 2 client2
    int m_len;        // length sampled at grant
    int m_left;       // beats still to transfer
    bit m_finishing;  // burst over, completion cycle pending
    bit m_aborted;
    int m_stall;
    int cnt1, cnt2;   // beats delivered by each client in its current burst
    int obs_beats;    // beat strobes seen from the DUT in the current burst

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0; m_len = 0; m_left = 0;
        m_finishing = 1'b0; m_aborted = 1'b0; m_stall = 0;
        obs_beats = 0;
    endtask

    task automatic model_start(input int owner, input int len);
        m_owner = owner; m_len = len; m_left = len; m_stall = 0;
        obs_beats = 0;
        if (owner == 1) cnt1 = 0; else cnt2 = 0;
        if (len == 0) m_finishing = 1'b1;
    endtask

    // Apply one clock edge worth of burst rules to the reference.
    task automatic model_advance(input logic rn, input logic g1, input logic g2,
                                 input int l1, input int l2, input logic rdy);
        if (!rn) begin
            model_reset();
        end else if (m_finishing) begin
            m_finishing = 1'b0; m_aborted = 1'b0; m_owner = 0;
        end else if (m_left > 0) begin
            if (rdy) begin
                if (m_owner == 1) cnt1++; else cnt2++;
                m_left--;
                m_stall = 0;
                if (m_left == 0) m_finishing = 1'b1;
            end else begin
`ifdef XFER_TIMEOUT_EN
                m_stall++;
                if (m_stall == int'(TIMEOUT_CYCLES)) begin
                    m_finishing = 1'b1; m_aborted = 1'b1; m_left = 0;
                end
`endif
            end
        end else if (g1) begin
            model_start(1, l1);
        end else if (g2) begin
            model_start(2, l2);
        end
    endtask

    task automatic check_outputs();
        logic              e_valid, e_req1, e_req2, e_done1, e_done2, e_abort, e_busy;
        logic [DATA_W-1:0] e_data;
        logic [1:0]        e_owner;
        e_valid = 1'b0; e_req1 = 1'b0; e_req2 = 1'b0; e_done1 = 1'b0;
        e_done2 = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
        e_data = '0; e_owner = 2'b00;
        if (m_finishing) begin
            e_busy = 1'b1;
            if (m_aborted) e_abort = 1'b1;
            else if (m_owner == 1) e_done1 = 1'b1;
            else e_done2 = 1'b1;
        end else if (m_left > 0) begin
            e_valid = 1'b1;
            e_busy  = 1'b1;
            e_owner = (m_owner == 1) ? 2'b01 : 2'b10;
            e_data  = (m_owner == 1) ? DATA_W'(C1_BASE + cnt1) : DATA_W'(C2_BASE + cnt2);
            e_req1  = (m_owner == 1) && bus_ready;
            e_req2  = (m_owner == 2) && bus_ready;
        end
        check_eq("valid", 32'(o_bus_valid), 32'(e_valid));
        check_eq("data",  32'(o_bus_data),  32'(e_data));
        if (!m_finishing) check_eq("owner", 32'(o_bus_owner), 32'(e_owner));
        check_eq("req1",  32'(o_beat_req1), 32'(e_req1));
        check_eq("req2",  32'(o_beat_req2), 32'(e_req2));
        check_eq("done1", 32'(o_done1),     32'(e_done1));
        check_eq("done2", 32'(o_done2),     32'(e_done2));
        check_eq("abort", 32'(o_abort),     32'(e_abort));
        check_eq("busy",  32'(o_busy),      32'(e_busy));
        if (o_beat_req1 || o_beat_req2) obs_beats++;
        if (m_finishing && !m_aborted) check_eq("burst_beats", 32'(obs_beats), 32'(m_len));
    endtask

    // One cycle: drive inputs, check mid-cycle, then advance the model at the edge.
    task automatic step(input logic rn, input logic g1, input logic g2,
                        input int l1, input int l2, input logic rdy);
        reset_n      = rn;
        i_grant1     = g1;
        i_grant2     = g2;
        client1_len  = LEN_W'(l1);
        client2_len  = LEN_W'(l2);
        bus_ready    = rdy;
        client1_data = DATA_W'(C1_BASE + cnt1);
        client2_data = DATA_W'(C2_BASE + cnt2);
        if (!rn) model_reset();
        #3;
        check_outputs();
        @(posedge clock);
        model_advance(rn, g1, g2, l1, l2, rdy);
        #1;
    endtask

    initial begin
        cnt1 = 0; cnt2 = 0;
        model_reset();

        // Reset held with a grant pending, then released: IDLE outputs, then a
        // 3-beat client1 burst from the grant still high at release.
        repeat (3) step(1'b0, 1'b1, 1'b0, 3, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3, 0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 3, 0, 1'b1);

        // Backpressure on a 2-beat client2 burst.
        step(1'b1, 1'b0, 1'b1, 0, 2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 0, 2, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 0, 2, 1'b1);

        // Simultaneous grants: client1 owns.
        step(1'b1, 1'b1, 1'b1, 2, 3, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0, 2, 3, 1'b1);

        // Zero-length client2 burst.
        step(1'b1, 1'b0, 1'b1, 0, 0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 0, 0, 1'b1);

        // Grant dropped after the first beat of four.
        step(1'b1, 1'b1, 1'b0, 4, 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 4, 0, 1'b1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 4, 0, 1'b1);

        // Reset pulsed after two beats of four: burst abandoned silently.
        step(1'b1, 1'b1, 1'b0, 4, 0, 1'b1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 4, 0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 4, 0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 4, 0, 1'b1);

        // Long stall: waits without the timeout build, aborts with it.
        step(1'b1, 1'b1, 1'b0, 3, 0, 1'b0);
        repeat (22) step(1'b1, 1'b0, 1'b0, 3, 0, 1'b0);
        repeat (5) step(1'b1, 1'b0, 1'b0, 3, 0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 5)),
                 int'($urandom_range(0, 5)),
                 ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
